// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - request/ack bus between a requester and the data-memory responder
interface dmem_responder_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        ack;
  logic [31:0] rdata;
  logic        err;
  logic        busy;

  modport master (
    output req, we, addr, wdata, be,
    input  ack, rdata, err, busy
  );

  modport slave (
    input  req, we, addr, wdata, be,
    output ack, rdata, err, busy
  );
endinterface

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - word-addressed data memory answering one request at a time
// after a fixed latency, with byte-lane writes and address range checking.
module dmem_responder #(
  parameter int ADDR_WORDS = 256,
  parameter int LATENCY    = 2
) (
  input logic               clk,
  input logic               rst,
  dmem_responder_if.slave   bus
);
  localparam int IDX_W = (ADDR_WORDS > 1) ? $clog2(ADDR_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        cap_we;
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;
  logic [3:0]  cap_be;

  logic [31:0] mem [ADDR_WORDS];

  logic             accept;
  logic             to_resp;
  logic             cur_we;
  logic [31:0]      cur_addr;
  logic [31:0]      cur_wdata;
  logic [3:0]       cur_be;
  logic             cur_err;
  logic [IDX_W-1:0] cur_idx;

  // With LATENCY=1 the response is built on the acceptance edge itself, so the
  // live bus values stand in for the not-yet-captured registers.
  always_comb begin
    accept    = !rst && (state == IDLE) && bus.req;
    cur_we    = accept ? bus.we    : cap_we;
    cur_addr  = accept ? bus.addr  : cap_addr;
    cur_wdata = accept ? bus.wdata : cap_wdata;
    cur_be    = accept ? bus.be    : cap_be;
    cur_err   = (cur_addr[1:0] != 2'b00) ||
                ({2'b00, cur_addr[31:2]} >= 32'(ADDR_WORDS));
    cur_idx   = cur_addr[IDX_W+1:2];
    to_resp   = (accept && (LATENCY == 1)) || ((state == WAIT) && (cnt == 4'd1));
  end

  // The array has no reset; a reset abandons the transfer because the FSM is
  // forced out of WAIT, so to_resp never fires for it.
  always_ff @(posedge clk) begin
    if (to_resp && cur_we && !cur_err) begin
      for (int i = 0; i < 4; i++) begin
        if (cur_be[i]) begin
          mem[cur_idx][8*i +: 8] <= cur_wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      cap_we    <= 1'b0;
      cap_addr  <= 32'd0;
      cap_wdata <= 32'd0;
      cap_be    <= 4'd0;
      bus.ack   <= 1'b0;
      bus.err   <= 1'b0;
      bus.rdata <= 32'd0;
      bus.busy  <= 1'b0;
    end else begin
      bus.ack   <= 1'b0;
      bus.err   <= 1'b0;
      bus.rdata <= 32'd0;
      case (state)
        IDLE: begin
          if (accept) begin
            cap_we    <= bus.we;
            cap_addr  <= bus.addr;
            cap_wdata <= bus.wdata;
            cap_be    <= bus.be;
            bus.busy  <= 1'b1;
            if (LATENCY == 1) begin
              state <= RESP;
            end else begin
              state <= WAIT;
              cnt   <= 4'(LATENCY - 1);
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd1) begin
            state <= RESP;
            cnt   <= 4'd0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
      if (to_resp) begin
        bus.ack   <= 1'b1;
        bus.err   <= cur_err;
        bus.rdata <= (!cur_we && !cur_err) ? mem[cur_idx] : 32'd0;
      end
    end
  end
endmodule
